// File: rtl/equiv_sweep_checker.sv
// ---------------------------------------------------------------------------
// equiv_sweep_checker
//
// Self-running equivalence checker for two combinational implementations of
// the same function. Every input vector 0 .. 2^IN_W-1 is driven on vec_out
// and held for SETTLE cycles. The two implementation outputs are then
// compared for one cycle. The checker records the mismatch count, the number
// of vectors compared, and the first failing vector. All results stay in
// registers, so they can be read on-chip or from a testbench.
//
// Parameters
//   IN_W    width of the swept input vector (1..16)
//   OUT_W   width of each implementation's output
//   SETTLE  cycles between driving a vector and comparing (>= 1)
//
// Ports
//   clk               system clock, all state on the rising edge
//   rst               synchronous active-high reset, aborts any sweep
//   start             single-cycle pulse, starts a sweep from IDLE or DONE
//   stop_on_fail      sampled with start; 1 ends the sweep at first mismatch
//   vec_out           vector driven to both implementations
//   ref_in            reference implementation output
//   dut_in            output of the implementation under check
//   busy              high while sweeping
//   done              high from sweep end until next start or rst
//   pass              done and no mismatches
//   fail_count        number of mismatching vectors
//   checked_count     number of vectors compared
//   first_fail_valid  a mismatch has been recorded
//   first_fail_vec    first mismatching vector
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | after reset, waiting for start
// SETTLE | vec_out driven, waiting SETTLE cycles for the logic to settle
// CHECK  | compare ref_in against dut_in, then advance or finish
// DONE   | results held; start begins a fresh sweep
// ---------------------------------------------------------------------------
module equiv_sweep_checker #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop_on_fail,
    output logic [IN_W-1:0]   vec_out,
    input  logic [OUT_W-1:0]  ref_in,
    input  logic [OUT_W-1:0]  dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IN_W:0]     fail_count,
    output logic [IN_W:0]     checked_count,
    output logic              first_fail_valid,
    output logic [IN_W-1:0]   first_fail_vec
);

    // Counter only needs to reach SETTLE-1; keep at least one bit.
    localparam int                CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  CNT_INC  = CNT_W'(1);
    localparam logic [IN_W-1:0]   VEC_LAST = '1;
    localparam logic [IN_W-1:0]   VEC_INC  = IN_W'(1);
    localparam logic [IN_W:0]     STAT_INC = (IN_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    logic               stop_latched;
    logic               mismatch;
    logic [IN_W:0]      fail_next;

    assign mismatch  = (ref_in != dut_in);
    // pass is decided on the DONE-entry edge, so it must see the count
    // that includes the vector being checked in that same cycle.
    assign fail_next = mismatch ? (fail_count + STAT_INC) : fail_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            settle_cnt       <= '0;
            stop_latched     <= 1'b0;
            vec_out          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail_count       <= '0;
            checked_count    <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_out          <= '0;
                        settle_cnt       <= '0;
                        fail_count       <= '0;
                        checked_count    <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        stop_latched     <= stop_on_fail;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        state            <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_INC;
                    if (settle_cnt == CNT_LAST) begin
                        state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    checked_count <= checked_count + STAT_INC;
                    fail_count    <= fail_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec_out;
                    end
                    // The last-vector test comes before any increment,
                    // so vec_out never wraps.
                    if ((vec_out == VEC_LAST) || (stop_latched && mismatch)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_next == '0);
                        state <= S_DONE;
                    end else begin
                        vec_out    <= vec_out + VEC_INC;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/equiv_sweep_checker.md
Name: equiv_sweep_checker

Overview:
- Synthesizable, self-running equivalence checker for two combinational implementations of the same function (for example, unminimized vs minimized).
- Sweeps every input vector 0..2^IN_W-1 on a shared input bus and waits a programmable settle time per vector.
- Compares the two implementations' outputs and accumulates mismatch statistics.
- Successor to the single-width, display-only comparison: generalised in input/output width, settle time and stop-on-fail mode, with results held in registers for on-chip or bench readout.

Parameters:
- IN_W, 3, width of the swept input vector (1..16).
- OUT_W, 1, width of each implementation's output.
- SETTLE, 1, clock cycles between driving a vector and comparing (>=1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a sweep from IDLE or DONE.
- stop_on_fail  input  1  sampled at start; 1 = end the sweep at the first mismatch.
- vec_out  output  IN_W  input vector driven to both implementations.
- ref_in  input  OUT_W  output of the reference implementation.
- dut_in  input  OUT_W  output of the implementation under check.
- busy  output  1  high while sweeping.
- done  output  1  high from sweep end until next start or rst.
- pass  output  1  done and fail_count==0.
- fail_count  output  IN_W+1  number of mismatching vectors.
- checked_count  output  IN_W+1  number of vectors compared.
- first_fail_valid  output  1  a mismatch has been recorded.
- first_fail_vec  output  IN_W  first mismatching vector.

Behaviour:
- Reset values: state IDLE, and all of the following are 0: vec_out, busy, done, pass, fail_count, checked_count, first_fail_valid, first_fail_vec.
- Reset mid-sweep: rst takes priority over every other input and aborts the sweep immediately.
- States:
  - IDLE/DONE, start=1: vec_out<=0, settle counter<=0, clear all counts and flags, latch stop_on_fail, go to SETTLE. busy=1 from the next cycle.
  - SETTLE: counter increments each cycle. When counter==SETTLE-1, go to CHECK.
  - CHECK: mismatch = (ref_in != dut_in), sampled this cycle.
    - checked_count increments.
    - On mismatch, fail_count increments. If first_fail_valid==0, set it and load first_fail_vec<=vec_out.
    - If vec_out==2^IN_W-1, or (latched stop_on_fail and mismatch), go to DONE.
    - Otherwise vec_out increments, counter<=0, go to SETTLE.
  - DONE: busy=0, done=1, pass=(fail_count==0). vec_out holds its last value.
- start is ignored while busy.
- Timing: each vector takes SETTLE+1 cycles. A full sweep sets done exactly 2^IN_W*(SETTLE+1) cycles after the start cycle.
- Arithmetic:
  - Counts are IN_W+1 bits, so the value 2^IN_W is representable without wrap.
  - vec_out never wraps; the last-vector test occurs before any increment.
- pass and done are registered and update in the same cycle as the DONE entry.

Test Plan:
- IN_W=3, SETTLE=1, identical ref/dut functions, start pulse -> done at cycle 16, checked_count=8, fail_count=0, pass=1, first_fail_valid=0.
- dut differs from ref only at vector 5, stop_on_fail=0 -> checked_count=8, fail_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
- dut differs at vectors 2 and 6, stop_on_fail=1 -> done at cycle 6, checked_count=3, fail_count=1, first_fail_vec=2, vec_out=2.
- SETTLE=3, dut output delayed 2 cycles relative to vec_out -> no false mismatches, fail_count=0, sweep takes 32 cycles.
- rst asserted during CHECK of vector 4 -> next cycle all outputs 0, IDLE; a new start yields a clean full sweep.
- start pulsed while busy, and again in DONE -> first pulse ignored, no count disturbance; second pulse clears results and restarts from vector 0.
